// File: rtl/centroid_pkg.sv
// Shared types and constants for the centroid post-processing scheduler.
package centroid_pkg;

  typedef enum logic [3:0] {
    IDLE,
    REQ_X,
    WAIT_X,
    REQ_Y,
    WAIT_Y,
    REQ_R,
    WAIT_R,
    REQ_S,
    WAIT_S,
    PUBLISH
  } state_t;

  localparam int unsigned X_MAX = 2047;
  localparam int unsigned Y_MAX = 1023;

  typedef logic [31:0] operand_t;

  // Multiplier must fit in 3 bits so the 35-bit product cannot wrap.
  function automatic operand_t sat_scale(input operand_t value, input int unsigned mul);
    logic [34:0] prod;
    prod = 35'(value) * 35'(mul);
    if (prod[34:32] != 3'b000) begin
      return '1;
    end
    return prod[31:0];
  endfunction

endpackage

// File: rtl/centroid_sched_sat_div_req.sv
// Divider request port: holds operands and valid until accepted, and clamps
// the returned quotient to the ceiling of the job currently in flight.
module sat_div_req
  import centroid_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     load,
  input  logic     abort,
  input  operand_t dividend_next,
  input  operand_t divisor_next,
  input  operand_t sat_max,
  output operand_t div_dividend,
  output operand_t div_divisor,
  output logic     div_in_valid,
  input  logic     div_in_ready,
  input  operand_t div_quotient,
  output logic     accepted,
  output operand_t quotient_sat
);

  operand_t dividend_reg;
  operand_t divisor_reg;
  logic     valid_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      dividend_reg <= '0;
      divisor_reg  <= '0;
      valid_reg    <= 1'b0;
    end else if (load) begin
      dividend_reg <= dividend_next;
      divisor_reg  <= divisor_next;
      valid_reg    <= 1'b1;
    end else if (abort || (valid_reg && div_in_ready)) begin
      valid_reg <= 1'b0;
    end
  end

  assign div_dividend = dividend_reg;
  assign div_divisor  = divisor_reg;
  assign div_in_valid = valid_reg;
  assign accepted     = valid_reg && div_in_ready;
  assign quotient_sat = (div_quotient > sat_max) ? sat_max : div_quotient;

endmodule

// File: rtl/centroid_sched.sv
// Per-frame centroid/radius scheduler sharing one divider and one sqrt core.
// Optional watchdog on every request/wait state: define CENTROID_TIMEOUT_EN.
module centroid_sched
  import centroid_pkg::*;
#(
  parameter int unsigned MIN_PIXELS  = 16,
  parameter int unsigned AREA_MUL    = 7,
  parameter int unsigned AREA_DIV    = 22,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_done,
  input  logic [31:0] size_in,
  input  logic [31:0] sum_x_in,
  input  logic [31:0] sum_y_in,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_in_valid,
  input  logic        div_in_ready,
  input  logic [31:0] div_quotient,
  input  logic        div_out_valid,
  output logic [31:0] sqrt_operand,
  output logic        sqrt_in_valid,
  input  logic        sqrt_in_ready,
  input  logic [15:0] sqrt_result,
  input  logic        sqrt_out_valid,
  output logic [10:0] x_center,
  output logic [9:0]  y_center,
  output logic [15:0] radius,
  output logic        target_found,
  output logic        result_valid,
  output logic        busy,
  output logic [7:0]  overrun_count
`ifdef CENTROID_TIMEOUT_EN
  ,
  output logic        timeout_flag
`endif
);

  state_t   state_reg, state_next;
  operand_t size_reg;
  operand_t sum_y_reg;
  operand_t r2_reg;
  logic [10:0] x_res_reg;
  logic [9:0]  y_res_reg;
  logic [15:0] rad_res_reg;
  logic        found_pend_reg;
  logic        sqrt_valid_reg;

  logic [10:0] x_center_reg;
  logic [9:0]  y_center_reg;
  logic [15:0] radius_reg;
  logic        target_found_reg;
  logic        result_valid_reg;
  logic [7:0]  overrun_count_reg;

  logic     div_load;
  logic     sqrt_load;
  logic     div_accepted;
  logic     timeout_hit;
  operand_t div_dividend_next;
  operand_t div_divisor_next;
  operand_t sat_max;
  operand_t quotient_sat;

  sat_div_req u_div_req (
    .clk           (clk),
    .reset         (reset),
    .load          (div_load),
    .abort         (timeout_hit),
    .dividend_next (div_dividend_next),
    .divisor_next  (div_divisor_next),
    .sat_max       (sat_max),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_in_valid  (div_in_valid),
    .div_in_ready  (div_in_ready),
    .div_quotient  (div_quotient),
    .accepted      (div_accepted),
    .quotient_sat  (quotient_sat)
  );

  // The X request loads straight from the frame inputs on the same edge that
  // latches them, so REQ_X already presents valid operands in its first cycle.
  always_comb begin
    state_next        = state_reg;
    div_load          = 1'b0;
    sqrt_load         = 1'b0;
    div_dividend_next = '0;
    div_divisor_next  = '0;
    sat_max           = '1;
    case (state_reg)
      IDLE: begin
        if (frame_done) begin
          if (size_in < MIN_PIXELS) begin
            state_next = PUBLISH;
          end else begin
            state_next        = REQ_X;
            div_load          = 1'b1;
            div_dividend_next = sum_x_in;
            div_divisor_next  = size_in;
          end
        end
      end
      REQ_X: if (div_accepted) state_next = WAIT_X;
      WAIT_X: begin
        sat_max = 32'(X_MAX);
        if (div_out_valid) begin
          state_next        = REQ_Y;
          div_load          = 1'b1;
          div_dividend_next = sum_y_reg;
          div_divisor_next  = size_reg;
        end
      end
      REQ_Y: if (div_accepted) state_next = WAIT_Y;
      WAIT_Y: begin
        sat_max = 32'(Y_MAX);
        if (div_out_valid) begin
          state_next        = REQ_R;
          div_load          = 1'b1;
          div_dividend_next = sat_scale(size_reg, AREA_MUL);
          div_divisor_next  = 32'(AREA_DIV);
        end
      end
      REQ_R: if (div_accepted) state_next = WAIT_R;
      WAIT_R: begin
        if (div_out_valid) begin
          state_next = REQ_S;
          sqrt_load  = 1'b1;
        end
      end
      REQ_S:   if (sqrt_valid_reg && sqrt_in_ready) state_next = WAIT_S;
      WAIT_S:  if (sqrt_out_valid) state_next = PUBLISH;
      PUBLISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (timeout_hit) begin
      state_next = PUBLISH;
      div_load   = 1'b0;
      sqrt_load  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg         <= IDLE;
      size_reg          <= '0;
      sum_y_reg         <= '0;
      r2_reg            <= '0;
      x_res_reg         <= '0;
      y_res_reg         <= '0;
      rad_res_reg       <= '0;
      found_pend_reg    <= 1'b0;
      sqrt_valid_reg    <= 1'b0;
      x_center_reg      <= '0;
      y_center_reg      <= '0;
      radius_reg        <= '0;
      target_found_reg  <= 1'b0;
      result_valid_reg  <= 1'b0;
      overrun_count_reg <= '0;
    end else begin
      state_reg <= state_next;

      if (state_reg == IDLE && frame_done) begin
        size_reg       <= size_in;
        sum_y_reg      <= sum_y_in;
        found_pend_reg <= (size_in >= MIN_PIXELS);
      end else if (timeout_hit) begin
        found_pend_reg <= 1'b0;
      end

      if (frame_done && state_reg != IDLE && overrun_count_reg != 8'hFF) begin
        overrun_count_reg <= overrun_count_reg + 8'd1;
      end

      if (div_out_valid) begin
        case (state_reg)
          WAIT_X:  x_res_reg <= quotient_sat[10:0];
          WAIT_Y:  y_res_reg <= quotient_sat[9:0];
          WAIT_R:  r2_reg    <= quotient_sat;
          default: ;
        endcase
      end
      if (state_reg == WAIT_S && sqrt_out_valid) begin
        rad_res_reg <= sqrt_result;
      end

      if (sqrt_load) begin
        sqrt_valid_reg <= 1'b1;
      end else if (timeout_hit || (sqrt_valid_reg && sqrt_in_ready)) begin
        sqrt_valid_reg <= 1'b0;
      end

      // Empty and aborted frames publish found=0 but keep the last good geometry.
      result_valid_reg <= (state_reg == PUBLISH);
      if (state_reg == PUBLISH) begin
        target_found_reg <= found_pend_reg;
        if (found_pend_reg) begin
          x_center_reg <= x_res_reg;
          y_center_reg <= y_res_reg;
          radius_reg   <= rad_res_reg;
        end
      end
    end
  end

`ifdef CENTROID_TIMEOUT_EN
  logic [31:0] wd_cnt_reg;
  logic        timeout_flag_reg;
  logic        wd_active;

  assign wd_active   = (state_reg != IDLE) && (state_reg != PUBLISH);
  assign timeout_hit = wd_active && (wd_cnt_reg == TIMEOUT_CYC - 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_cnt_reg       <= '0;
      timeout_flag_reg <= 1'b0;
    end else begin
      if (state_next != state_reg) begin
        wd_cnt_reg <= '0;
      end else if (wd_active) begin
        wd_cnt_reg <= wd_cnt_reg + 32'd1;
      end
      if (timeout_hit) begin
        timeout_flag_reg <= 1'b1;
      end
    end
  end

  assign timeout_flag = timeout_flag_reg;
`else
  assign timeout_hit = 1'b0;
`endif

  assign sqrt_operand  = r2_reg;
  assign sqrt_in_valid = sqrt_valid_reg;
  assign x_center      = x_center_reg;
  assign y_center      = y_center_reg;
  assign radius        = radius_reg;
  assign target_found  = target_found_reg;
  assign result_valid  = result_valid_reg;
  assign busy          = (state_reg != IDLE);
  assign overrun_count = overrun_count_reg;

endmodule

// File: tb/tb_centroid_sched.sv
// Self-checking bench for centroid_sched: emulated divider/sqrt cores with
// variable latency and backpressure, checked against an arithmetic model.
module tb_centroid_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_done = 1'b0;
  logic [31:0] size_in = '0;
  logic [31:0] sum_x_in = '0;
  logic [31:0] sum_y_in = '0;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_in_valid;
  logic        div_in_ready = 1'b0;
  logic [31:0] div_quotient = '0;
  logic        div_out_valid = 1'b0;
  logic [31:0] sqrt_operand;
  logic        sqrt_in_valid;
  logic        sqrt_in_ready = 1'b0;
  logic [15:0] sqrt_result = '0;
  logic        sqrt_out_valid = 1'b0;
  logic [10:0] x_center;
  logic [9:0]  y_center;
  logic [15:0] radius;
  logic        target_found;
  logic        result_valid;
  logic        busy;
  logic [7:0]  overrun_count;

  centroid_sched dut (
    .clk            (clk),
    .reset          (reset),
    .frame_done     (frame_done),
    .size_in        (size_in),
    .sum_x_in       (sum_x_in),
    .sum_y_in       (sum_y_in),
    .div_dividend   (div_dividend),
    .div_divisor    (div_divisor),
    .div_in_valid   (div_in_valid),
    .div_in_ready   (div_in_ready),
    .div_quotient   (div_quotient),
    .div_out_valid  (div_out_valid),
    .sqrt_operand   (sqrt_operand),
    .sqrt_in_valid  (sqrt_in_valid),
    .sqrt_in_ready  (sqrt_in_ready),
    .sqrt_result    (sqrt_result),
    .sqrt_out_valid (sqrt_out_valid),
    .x_center       (x_center),
    .y_center       (y_center),
    .radius         (radius),
    .target_found   (target_found),
    .result_valid   (result_valid),
    .busy           (busy),
    .overrun_count  (overrun_count)
  );

  always #5 clk = ~clk;

  // Core emulation knobs (written by the stimulus, read by the responder).
  int div_lat = 3, sqrt_lat = 3;
  int div_mode = 0, sqrt_mode = 0;  // 0 always ready, 1 random, 2 stalled

  // Responder/monitor state.
  int          div_cnt = 0, sqrt_cnt = 0;
  int          div_hs = 0, sqrt_hs = 0, rv_count = 0, viol = 0;
  logic [31:0] div_res = '0, div_a = '0, div_b = '0, sq_a = '0;
  logic [15:0] sq_res = '0;
  logic        div_hold = 1'b0, sq_hold = 1'b0, rv_prev = 1'b0;

  function automatic logic [15:0] isqrt(input logic [31:0] v);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (32'd1 << b);
      if (t * t <= v) r = t;
    end
    return r[15:0];
  endfunction

  // Inputs change on the falling edge so the DUT samples them cleanly.
  always @(negedge clk) begin
    div_out_valid = 1'b0;
    if (div_cnt > 0) begin
      div_cnt--;
      if (div_cnt == 0) begin
        div_out_valid = 1'b1;
        div_quotient  = div_res;
      end
    end
    if (div_hold && !(div_in_valid && div_dividend == div_a && div_divisor == div_b)) viol++;
    div_in_ready = (div_mode == 0) ? 1'b1 : (div_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (div_in_valid && div_in_ready) begin
      if (div_cnt != 0 || sqrt_cnt != 0) viol++;
      div_res = (div_divisor == 0) ? '1 : div_dividend / div_divisor;
      div_cnt = div_lat;
      div_hs++;
    end
    div_hold = div_in_valid && !div_in_ready;
    div_a    = div_dividend;
    div_b    = div_divisor;

    sqrt_out_valid = 1'b0;
    if (sqrt_cnt > 0) begin
      sqrt_cnt--;
      if (sqrt_cnt == 0) begin
        sqrt_out_valid = 1'b1;
        sqrt_result    = sq_res;
      end
    end
    if (sq_hold && !(sqrt_in_valid && sqrt_operand == sq_a)) viol++;
    sqrt_in_ready = (sqrt_mode == 0) ? 1'b1 : (sqrt_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (sqrt_in_valid && sqrt_in_ready) begin
      if (div_cnt != 0 || sqrt_cnt != 0) viol++;
      sq_res   = isqrt(sqrt_operand);
      sqrt_cnt = sqrt_lat;
      sqrt_hs++;
    end
    sq_hold = sqrt_in_valid && !sqrt_in_ready;
    sq_a    = sqrt_operand;

    if (result_valid) begin
      rv_count++;
      if (rv_prev) viol++;
    end
    rv_prev = result_valid;
  end

  int          checks = 0, errors = 0;
  logic [31:0] exp_x = '0, exp_y = '0, exp_r = '0;
  logic        exp_found = 1'b0;
  int          exp_ovr = 0, exp_rv = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: what one accepted frame should publish.
  task automatic model_publish(input logic [31:0] s, input logic [31:0] sx, input logic [31:0] sy);
    longint unsigned area;
    longint unsigned r2;
    exp_rv++;
    if (s >= 32'd16) begin
      exp_x = (sx / s > 32'd2047) ? 32'd2047 : sx / s;
      exp_y = (sy / s > 32'd1023) ? 32'd1023 : sy / s;
      area  = 64'(s) * 64'd7;
      if (area > 64'hFFFF_FFFF) area = 64'hFFFF_FFFF;
      r2    = area / 64'd22;
      exp_r = 32'($rtoi($sqrt(real'(r2))));
      exp_found = 1'b1;
    end else begin
      exp_found = 1'b0;
    end
  endtask

  task automatic pulse_frame(input logic [31:0] s, input logic [31:0] sx, input logic [31:0] sy);
    size_in    = s;
    sum_x_in   = sx;
    sum_y_in   = sy;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    for (int i = 0; i < 3000 && !result_valid; i++) tick();
    check({tag, "_rv"}, 32'(result_valid), 32'd1);
  endtask

  task automatic wait_div_hs(input string tag, input int target);
    for (int i = 0; i < 500 && div_hs < target; i++) tick();
    check({tag, "_div_hs"}, div_hs, target);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_x"}, 32'(x_center), exp_x);
    check({tag, "_y"}, 32'(y_center), exp_y);
    check({tag, "_r"}, 32'(radius), exp_r);
    check({tag, "_found"}, 32'(target_found), 32'(exp_found));
    $display("frame %s: x=%0d y=%0d r=%0d found=%0d ovr=%0d", tag, x_center, y_center,
             radius, target_found, overrun_count);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_x"}, 32'(x_center), 32'd0);
    check({tag, "_y"}, 32'(y_center), 32'd0);
    check({tag, "_r"}, 32'(radius), 32'd0);
    check({tag, "_found"}, 32'(target_found), 32'd0);
    check({tag, "_rv"}, 32'(result_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ovr"}, 32'(overrun_count), 32'd0);
    check({tag, "_divv"}, 32'({div_in_valid, sqrt_in_valid}), 32'd0);
    check({tag, "_ops"}, div_dividend | div_divisor | sqrt_operand, 32'd0);
  endtask

  initial begin
    int h0, s0, r0;
    logic [31:0] s, sx, sy;

    // Reset state
    repeat (3) tick();
    check_reset_state("reset");
    reset = 1'b1;
    tick();

    // Basic frame with 40-cycle cores
    div_lat = 40; sqrt_lat = 40;
    h0 = div_hs; s0 = sqrt_hs;
    pulse_frame(32'd100, 32'd50000, 32'd30000);
    model_publish(32'd100, 32'd50000, 32'd30000);
    wait_result("basic");
    check_outputs("basic");
    check("basic_r_abs", 32'(radius), 32'd5);
    tick();
    check("basic_rv_pulses", rv_count, exp_rv);
    check("basic_div_hs", div_hs - h0, 32'd3);
    check("basic_sqrt_hs", sqrt_hs - s0, 32'd1);

    // Empty target: publishes two cycles after frame_done, no core traffic
    h0 = div_hs; s0 = sqrt_hs;
    pulse_frame(32'd0, 32'd123, 32'd456);
    model_publish(32'd0, 32'd123, 32'd456);
    check("empty_rv_early", 32'(result_valid), 32'd0);
    check("empty_busy", 32'(busy), 32'd1);
    tick();
    check("empty_rv", 32'(result_valid), 32'd1);
    check_outputs("empty");
    check("empty_no_req", (div_hs - h0) + (sqrt_hs - s0), 32'd0);
    tick();

    // Threshold boundary: 15 is rejected, 16 accepted with x/y saturation
    div_lat = 2; sqrt_lat = 2;
    pulse_frame(32'd15, 32'd1000, 32'd1000);
    model_publish(32'd15, 32'd1000, 32'd1000);
    wait_result("min15");
    check_outputs("min15");
    tick();
    pulse_frame(32'd16, 32'd40000, 32'd20000);
    model_publish(32'd16, 32'd40000, 32'd20000);
    wait_result("min16sat");
    check_outputs("min16sat");
    tick();

    // Area saturation: size*7 overflows 32 bits
    pulse_frame(32'hFFFF_FFFF, 32'hFFFF_0000, 32'h1234_5678);
    model_publish(32'hFFFF_FFFF, 32'hFFFF_0000, 32'h1234_5678);
    wait_result("areasat");
    check_outputs("areasat");
    tick();

    // Backpressure on the Y request
    div_lat = 5;
    h0 = div_hs;
    pulse_frame(32'd100, 32'd50000, 32'd30000);
    model_publish(32'd100, 32'd50000, 32'd30000);
    wait_div_hs("bp_x", h0 + 1);
    div_mode = 2;
    for (int i = 0; i < 200 && !div_in_valid; i++) tick();
    check("bp_reqy_valid", 32'(div_in_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_op", {div_dividend[15:0], div_divisor[15:0]}, {16'd30000, 16'd100});
      check("bp_hold_valid", 32'(div_in_valid), 32'd1);
      tick();
    end
    check("bp_no_hs", div_hs - h0, 32'd1);
    div_mode = 0;
    wait_result("bp");
    check_outputs("bp");
    check("bp_hs_total", div_hs - h0, 32'd3);
    tick();

    // Two overruns while waiting on the X quotient
    div_lat = 40;
    h0 = div_hs;
    pulse_frame(32'd200, 32'd140000, 32'd80000);
    model_publish(32'd200, 32'd140000, 32'd80000);
    wait_div_hs("ovr_x", h0 + 1);
    repeat (3) tick();
    pulse_frame(32'd50, 32'd1, 32'd1);
    repeat (2) tick();
    pulse_frame(32'd60, 32'd2, 32'd2);
    exp_ovr += 2;
    check("ovr_count_mid", 32'(overrun_count), 32'(exp_ovr));
    wait_result("ovr");
    check_outputs("ovr");
    check("ovr_count", 32'(overrun_count), 32'(exp_ovr));
    tick();

    // Randomized frames with random latencies and backpressure
    for (int n = 0; n < 12; n++) begin
      div_lat   = $urandom_range(1, 12);
      sqrt_lat  = $urandom_range(1, 12);
      div_mode  = $urandom_range(0, 1);
      sqrt_mode = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0:       s = 32'($urandom_range(0, 20));
        1:       s = 32'($urandom_range(16, 5000));
        2:       s = 32'hFFFF_FFFF - 32'($urandom_range(0, 1000));
        default: s = 32'($urandom_range(16, 400));
      endcase
      if (s > 32'd5000) begin
        sx = $urandom;
        sy = $urandom;
      end else begin
        sx = s * 32'($urandom_range(0, 2200));
        sy = s * 32'($urandom_range(0, 1100));
      end
      pulse_frame(s, sx, sy);
      model_publish(s, sx, sy);
      wait_result("rand");
      check_outputs($sformatf("rand%0d", n));
      repeat ($urandom_range(1, 4)) tick();
    end
    div_mode = 0; sqrt_mode = 0;

    // Reset in WAIT_Y; the late quotient must be ignored
    div_lat = 40;
    h0 = div_hs;
    pulse_frame(32'd100, 32'd50000, 32'd30000);
    wait_div_hs("rst_y", h0 + 2);
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    check_reset_state("midreset");
    exp_x = '0; exp_y = '0; exp_r = '0; exp_found = 1'b0; exp_ovr = 0;
    r0 = rv_count;
    repeat (60) tick();
    check("midreset_no_rv", rv_count - r0, 32'd0);
    check("midreset_idle", 32'(busy), 32'd0);

    // Recovery frame
    div_lat = 4; sqrt_lat = 4;
    pulse_frame(32'd100, 32'd50000, 32'd30000);
    model_publish(32'd100, 32'd50000, 32'd30000);
    wait_result("recover");
    check_outputs("recover");
    repeat (3) tick();

    check("rv_pulse_total", rv_count, exp_rv);
    check("protocol_violations", viol, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
